// File: rtl/aurora_pkg.sv
// Shared types and widths for the 4-thread, 64-bit pipeline memory stage.
package aurora_pkg;

  localparam int PROC_DATA_WIDTH        = 64;
  localparam int PROC_REGFILE_LOG2_DEEP = 5;
  localparam int DMEM_ADDR_WIDTH        = 10;

  typedef logic [1:0] thread_id_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } mem_state_e;

  // Store wins over load when both flags are set.
  function automatic mem_op_e classify_op(input logic mem_write_en,
                                          input logic mem_to_reg);
    mem_op_e op;
    if (mem_write_en)    op = OP_STORE;
    else if (mem_to_reg) op = OP_LOAD;
    else                 op = OP_ALU;
    return op;
  endfunction

endpackage

// File: rtl/mem_stage_ctrl.sv
// EX/MEM consumer: classifies one op at a time, runs the data-memory
// request/response handshake, stalls upstream while a memory access is in
// flight, and emits a registered single-cycle writeback bundle.
module mem_stage_ctrl #(
  parameter int PROC_DATA_WIDTH        = aurora_pkg::PROC_DATA_WIDTH,
  parameter int PROC_REGFILE_LOG2_DEEP = aurora_pkg::PROC_REGFILE_LOG2_DEEP,
  parameter int DMEM_ADDR_WIDTH        = aurora_pkg::DMEM_ADDR_WIDTH
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              ex_valid_i,
  input  logic                              reg_write_en_i,
  input  logic                              mem_write_en_i,
  input  logic                              mem_to_reg_i,
  input  logic [PROC_DATA_WIDTH-1:0]        alu_i,
  input  logic [PROC_DATA_WIDTH-1:0]        reg_data2_i,
  input  logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_i,
  input  logic [1:0]                        thread_id_i,
  output logic                              stall_o,
  output logic                              dmem_req_valid_o,
  input  logic                              dmem_req_ready_i,
  output logic                              dmem_we_o,
  output logic [DMEM_ADDR_WIDTH-1:0]        dmem_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        dmem_wdata_o,
  input  logic                              dmem_rsp_valid_i,
  input  logic [PROC_DATA_WIDTH-1:0]        dmem_rsp_data_i,
  output logic                              wb_valid_o,
  output logic                              reg_write_en_o,
  output logic [PROC_REGFILE_LOG2_DEEP-1:0] reg_write_addr_o,
  output logic [PROC_DATA_WIDTH-1:0]        wb_data_o,
  output logic [1:0]                        thread_id_o,
  output logic                              protocol_err_o
);
  import aurora_pkg::*;

  mem_state_e                        state;
  mem_op_e                           op_in;
  logic                              lat_rwe;
  logic [PROC_REGFILE_LOG2_DEEP-1:0] lat_waddr;
  thread_id_t                        lat_tid;
  logic                              stray_rsp;

  assign op_in = classify_op(mem_write_en_i, mem_to_reg_i);

  // A response is only legal in WAIT, and never alongside a ready that
  // has no request to go with it. Stray data is dropped.
  assign stray_rsp = dmem_rsp_valid_i &&
                     ((state != WAIT) || (dmem_req_ready_i && !dmem_req_valid_o));

  // Upstream holds EX/MEM whenever a memory access is outstanding.
  assign stall_o = (state != IDLE);

  // Control FSM with registered memory-request and writeback outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state            <= IDLE;
      lat_rwe          <= 1'b0;
      lat_waddr        <= '0;
      lat_tid          <= '0;
      dmem_req_valid_o <= 1'b0;
      dmem_we_o        <= 1'b0;
      dmem_addr_o      <= '0;
      dmem_wdata_o     <= '0;
      wb_valid_o       <= 1'b0;
      reg_write_en_o   <= 1'b0;
      reg_write_addr_o <= '0;
      wb_data_o        <= '0;
      thread_id_o      <= '0;
      protocol_err_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      if (stray_rsp) protocol_err_o <= 1'b1;

      case (state)
        IDLE: begin
          if (ex_valid_i) begin
            lat_rwe   <= reg_write_en_i;
            lat_waddr <= reg_write_addr_i;
            lat_tid   <= thread_id_i;
            if (op_in == OP_ALU) begin
              // ALU results bypass memory and retire next cycle.
              wb_valid_o       <= 1'b1;
              wb_data_o        <= alu_i;
              reg_write_en_o   <= reg_write_en_i;
              reg_write_addr_o <= reg_write_addr_i;
              thread_id_o      <= thread_id_i;
            end else begin
              state            <= REQ;
              dmem_req_valid_o <= 1'b1;
              dmem_we_o        <= (op_in == OP_STORE);
              dmem_addr_o      <= alu_i[DMEM_ADDR_WIDTH+2:3];
              dmem_wdata_o     <= reg_data2_i;
            end
          end
        end

        REQ: begin
          if (dmem_req_ready_i) begin
            dmem_req_valid_o <= 1'b0;
            if (dmem_we_o) begin
              // Stores retire with a non-writing bundle to keep ordering.
              state            <= IDLE;
              wb_valid_o       <= 1'b1;
              reg_write_en_o   <= 1'b0;
              reg_write_addr_o <= lat_waddr;
              thread_id_o      <= lat_tid;
            end else begin
              state <= WAIT;
            end
          end
        end

        WAIT: begin
          if (dmem_rsp_valid_i && !stray_rsp) begin
            state            <= IDLE;
            wb_valid_o       <= 1'b1;
            wb_data_o        <= dmem_rsp_data_i;
            reg_write_en_o   <= lat_rwe;
            reg_write_addr_o <= lat_waddr;
            thread_id_o      <= lat_tid;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: issued ops push expected requests and
// writebacks; a memory model and a writeback monitor pop and compare.
module tb_mem_stage_ctrl;

  localparam int DW = 64;
  localparam int RW = 5;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          ex_valid_i, reg_write_en_i, mem_write_en_i, mem_to_reg_i;
  logic [DW-1:0] alu_i, reg_data2_i;
  logic [RW-1:0] reg_write_addr_i;
  logic [1:0]    thread_id_i;
  logic          stall_o, dmem_req_valid_o, dmem_req_ready_i, dmem_we_o;
  logic [AW-1:0] dmem_addr_o;
  logic [DW-1:0] dmem_wdata_o;
  logic          dmem_rsp_valid_i;
  logic [DW-1:0] dmem_rsp_data_i;
  logic          wb_valid_o, reg_write_en_o;
  logic [RW-1:0] reg_write_addr_o;
  logic [DW-1:0] wb_data_o;
  logic [1:0]    thread_id_o;
  logic          protocol_err_o;

  always #5 clk = ~clk;

  mem_stage_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .ex_valid_i(ex_valid_i),
    .reg_write_en_i(reg_write_en_i), .mem_write_en_i(mem_write_en_i),
    .mem_to_reg_i(mem_to_reg_i), .alu_i(alu_i), .reg_data2_i(reg_data2_i),
    .reg_write_addr_i(reg_write_addr_i), .thread_id_i(thread_id_i),
    .stall_o(stall_o), .dmem_req_valid_o(dmem_req_valid_o),
    .dmem_req_ready_i(dmem_req_ready_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_data_i(dmem_rsp_data_i),
    .wb_valid_o(wb_valid_o), .reg_write_en_o(reg_write_en_o),
    .reg_write_addr_o(reg_write_addr_o), .wb_data_o(wb_data_o),
    .thread_id_o(thread_id_o), .protocol_err_o(protocol_err_o)
  );

  typedef struct packed {
    logic          rwe;
    logic [RW-1:0] waddr;
    logic [1:0]    tid;
    logic          chk_data;
    logic [DW-1:0] data;
  } wb_exp_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_exp_t;

  wb_exp_t  wbq[$];
  req_exp_t rq[$];
  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] ref_m  [1024];
  logic [DW-1:0] dmem_m [1024];

  // memory model configuration (-1 = random per access)
  int            ready_delay_cfg = 0;
  int            rsp_delay_cfg   = 0;
  int            cur_rdy = 0;
  int            rdy_wait = 0;
  int            rsp_cnt = 0;
  bit            load_pending = 0;
  bit            inject_rsp = 0;
  logic [DW-1:0] rsp_buf = '0;

  function automatic logic [DW-1:0] init_val(int a);
    return 64'hA5A5_0000_0000_0000 ^ (64'(a) * 64'h9E37_79B9_7F4A_7C15);
  endfunction

  function automatic logic [AW-1:0] word_of(logic [DW-1:0] alu);
    return AW'((alu >> 3) % 1024);
  endfunction

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(string nm);
    checks++;
    fails++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  task automatic set_mem(int rd, int sd);
    ready_delay_cfg = rd;
    rsp_delay_cfg   = sd;
    cur_rdy  = (rd < 0) ? int'($urandom_range(0, 3)) : rd;
    rdy_wait = 0;
  endtask

  // Memory model: acts at negedge, checks the held request every cycle
  // it is presented, and answers loads from its own array.
  initial begin
    dmem_req_ready_i = 1'b0;
    dmem_rsp_valid_i = 1'b0;
    dmem_rsp_data_i  = '0;
    forever begin
      @(negedge clk);
      dmem_req_ready_i = 1'b0;
      dmem_rsp_valid_i = 1'b0;
      if (inject_rsp) begin
        dmem_rsp_valid_i = 1'b1;
        dmem_rsp_data_i  = 64'h0BAD_0BAD_0BAD_0BAD;
        inject_rsp = 0;
      end else if (rst_ni && dmem_req_valid_o) begin
        if (rq.size() == 0) begin
          chk("req_unexpected", 64'(rq.size()), 64'd1);
        end else begin
          chk("req_we",    dmem_we_o,    rq[0].we);
          chk("req_addr",  dmem_addr_o,  rq[0].addr);
          chk("req_wdata", dmem_wdata_o, rq[0].wdata);
          if (rdy_wait >= cur_rdy) begin
            dmem_req_ready_i = 1'b1;
            void'(rq.pop_front());
            if (dmem_we_o) begin
              dmem_m[dmem_addr_o] = dmem_wdata_o;
            end else begin
              load_pending = 1;
              rsp_buf = dmem_m[dmem_addr_o];
              rsp_cnt = (rsp_delay_cfg < 0) ? int'($urandom_range(0, 3)) : rsp_delay_cfg;
            end
            rdy_wait = 0;
            cur_rdy = (ready_delay_cfg < 0) ? int'($urandom_range(0, 3)) : ready_delay_cfg;
          end else begin
            rdy_wait++;
          end
        end
      end else if (load_pending) begin
        if (rsp_cnt == 0) begin
          dmem_rsp_valid_i = 1'b1;
          dmem_rsp_data_i  = rsp_buf;
          load_pending = 0;
        end else begin
          rsp_cnt--;
        end
      end
    end
  end

  // Writeback monitor: every pulse must match the oldest outstanding op.
  initial begin
    wb_exp_t e;
    forever begin
      @(negedge clk);
      if (rst_ni && wb_valid_o) begin
        if (wbq.size() == 0) begin
          chk("wb_spurious", 64'(wbq.size()), 64'd1);
        end else begin
          e = wbq.pop_front();
          chk("wb_rwe",   reg_write_en_o,   e.rwe);
          chk("wb_waddr", reg_write_addr_o, e.waddr);
          chk("wb_tid",   thread_id_o,      e.tid);
          if (e.chk_data) chk("wb_data", wb_data_o, e.data);
        end
      end
    end
  end

  // Reference model: ops retire in issue order; memory is a plain array.
  task automatic issue(bit mwe, bit m2r, bit rwe, logic [DW-1:0] alu,
                       logic [DW-1:0] d2, logic [RW-1:0] wa, logic [1:0] tid);
    int n = 0;
    logic [AW-1:0] w;
    while (stall_o) begin
      @(posedge clk); #1;
      if (++n > 200) begin
        timeout_fail("issue_wait_idle");
        return;
      end
    end
    w = word_of(alu);
    if (mwe) begin
      ref_m[w] = d2;
      rq.push_back('{1'b1, w, d2});
      wbq.push_back('{1'b0, wa, tid, 1'b0, 64'd0});
    end else if (m2r) begin
      rq.push_back('{1'b0, w, d2});
      wbq.push_back('{rwe, wa, tid, 1'b1, ref_m[w]});
    end else begin
      wbq.push_back('{rwe, wa, tid, 1'b1, alu});
    end
    ex_valid_i = 1'b1; mem_write_en_i = mwe; mem_to_reg_i = m2r;
    reg_write_en_i = rwe; alu_i = alu; reg_data2_i = d2;
    reg_write_addr_i = wa; thread_id_i = tid;
    @(posedge clk); #1;
    ex_valid_i = 1'b0;
  endtask

  task automatic drain(string nm);
    int n = 0;
    while (wbq.size() != 0 || stall_o) begin
      @(posedge clk); #1;
      if (++n > 500) begin
        timeout_fail(nm);
        return;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_stall"},  stall_o,          '0);
    chk({nm, "_reqv"},   dmem_req_valid_o, '0);
    chk({nm, "_we"},     dmem_we_o,        '0);
    chk({nm, "_addr"},   dmem_addr_o,      '0);
    chk({nm, "_wdata"},  dmem_wdata_o,     '0);
    chk({nm, "_wbv"},    wb_valid_o,       '0);
    chk({nm, "_rwe"},    reg_write_en_o,   '0);
    chk({nm, "_waddr"},  reg_write_addr_o, '0);
    chk({nm, "_wbdata"}, wb_data_o,        '0);
    chk({nm, "_tid"},    thread_id_o,      '0);
    chk({nm, "_err"},    protocol_err_o,   '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int a = 0; a < 1024; a++) begin
      ref_m[a]  = init_val(a);
      dmem_m[a] = init_val(a);
    end
    rst_ni = 1'b0; ex_valid_i = 1'b0; reg_write_en_i = 1'b0;
    mem_write_en_i = 1'b0; mem_to_reg_i = 1'b0; alu_i = '0; reg_data2_i = '0;
    reg_write_addr_i = '0; thread_id_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_ni = 1'b1;
    @(posedge clk); #1;

    // ALU pass-through
    set_mem(0, 0);
    issue(0, 0, 1, 64'h1234, 64'h0, 5'd7, 2'd2);
    chk("alu_stall", stall_o, 1'b0);
    drain("alu_drain");

    // store with ready held low for three cycles
    set_mem(3, 0);
    issue(1, 0, 1, 64'h40, 64'hDEAD, 5'd5, 2'd1);
    chk("store_stall", stall_o, 1'b1);
    chk("store_addr8", dmem_addr_o, 10'd8);
    drain("store_drain");

    // load answered five cycles after acceptance
    ref_m[3] = 64'hBEEF;
    dmem_m[3] = 64'hBEEF;
    set_mem(0, 4);
    issue(0, 1, 1, 64'h18, 64'h0, 5'd9, 2'd3);
    chk("load_addr3", dmem_addr_o, 10'd3);
    chk("load_we", dmem_we_o, 1'b0);
    drain("load_drain");

    // stray response in IDLE
    inject_rsp = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("err_set", protocol_err_o, 1'b1);
    issue(0, 0, 1, 64'hCAFE_F00D, 64'h0, 5'd0, 2'd0);
    drain("err_alu_drain");
    chk("err_sticky", protocol_err_o, 1'b1);

    // both flags set -> store; read it back
    set_mem(1, 0);
    issue(1, 1, 1, 64'h100, 64'h5, 5'd4, 2'd0);
    drain("both_drain");
    issue(0, 1, 1, 64'h100, 64'h0, 5'd6, 2'd1);
    drain("both_rd_drain");

    // reset while a load waits for its response
    set_mem(0, 8);
    issue(0, 1, 1, 64'h20, 64'h0, 5'd3, 2'd2);
    n = 0;
    while (dmem_req_valid_o || !stall_o) begin
      @(posedge clk); #1;
      if (++n > 50) begin
        timeout_fail("rst_wait_state");
        break;
      end
    end
    rst_ni = 1'b0;
    void'(wbq.pop_back());
    @(posedge clk); #1;
    check_zero("rst_mid");
    rst_ni = 1'b1;
    n = 0;
    while (load_pending) begin
      @(posedge clk); #1;
      if (++n > 50) begin
        timeout_fail("late_rsp_wait");
        break;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    chk("late_rsp_err", protocol_err_o, 1'b1);
    chk("late_rsp_state", stall_o, 1'b0);

    // randomized traffic over a small word window to exercise store->load
    set_mem(-1, -1);
    for (int i = 0; i < 200; i++) begin
      int kind;
      logic [DW-1:0] alu;
      kind = int'($urandom_range(0, 2));
      alu = (64'($urandom) << 13) | (64'($urandom_range(0, 15)) << 3) |
            64'($urandom_range(0, 7));
      issue(kind == 2, kind == 1 || $urandom_range(0, 3) == 0 && kind == 2,
            1'($urandom), alu, {$urandom, $urandom}, 5'($urandom), 2'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
